// File: rtl/emux_rxn.sv
// emux_rxn: parametrised N-channel UDP receive demux with per-frame IDLE/ACTIVE/DROP tracking.
// Frame/drop/abort statistics are built only when EMUX_RXN_STATS_EN is defined.
module emux_rxn #(
  parameter int NPORT = 4,
  parameter logic [NPORT*16-1:0] PORTS = '0,
  parameter int CW = 16,
  parameter int jumbo_dw = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [11:0] in_c,
  output logic [11:0] out_c,
  output logic [NPORT-1:0] ready,
  output logic strobe,
  output logic crc,
  output logic [7:0] data,
  output logic [3:0] sel_idx,
  output logic active,
  input  logic cnt_clear,
  output logic [NPORT*CW-1:0] frame_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic [CW-1:0] abort_cnt
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
  state_t state, state_nx;
  logic in_crc, in_s, in_p;
  logic [7:0] in_d;
  logic [NPORT-1:0] hi_match, hi_nx;
  logic [3:0] win, sel_nx;
  logic close_frame, close_drop, abort;
  assign in_crc = in_c[11];
  assign in_s = in_c[9];
  assign in_p = in_c[8];
  assign in_d = in_c[7:0];
  assign data = in_d;
  assign active = state == ACTIVE;
  assign strobe = in_s & active;
  // The port high byte arrives the cycle before the in_p strobe that carries the low byte.
  for (genvar k = 0; k < NPORT; k++) begin : g_ch
    assign hi_nx[k] = in_d == PORTS[16*k+8 +: 8];
    assign ready[k] = in_p && in_d == PORTS[16*k +: 8] && hi_match[k] && PORTS[16*k +: 16] != 16'd0;
  end
  always_comb begin
    win = '0;
    for (int k = NPORT - 1; k >= 0; k--) if (ready[k]) win = 4'(k);
  end
  // A coincident CRC closes the old frame before the new header takes effect.
  always_comb begin
    state_nx = state;
    sel_nx = sel_idx;
    close_frame = in_crc && state == ACTIVE;
    close_drop = in_crc && state == DROP;
    abort = in_p && !in_crc && state != IDLE;
    if (in_p) begin
      state_nx = |ready ? ACTIVE : DROP;
      sel_nx = |ready ? win : sel_idx;
    end else if (in_crc && state != IDLE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel_idx <= '0;
      hi_match <= '0;
      out_c <= '0;
      crc <= 1'b0;
    end else begin
      state <= state_nx;
      sel_idx <= sel_nx;
      hi_match <= hi_nx;
      out_c <= in_c;
      crc <= in_crc & active;
    end
`ifdef EMUX_RXN_STATS_EN
  logic [CW-1:0] fcnt [NPORT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NPORT; k++) fcnt[k] <= '0;
      drop_cnt <= '0;
      abort_cnt <= '0;
    end else if (cnt_clear) begin
      for (int k = 0; k < NPORT; k++) fcnt[k] <= '0;
      drop_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) if (close_frame && sel_idx == 4'(k)) fcnt[k] <= fcnt[k] + CW'(1);
      if (close_drop) drop_cnt <= drop_cnt + CW'(1);
      if (abort) abort_cnt <= abort_cnt + CW'(1);
    end
  for (genvar k = 0; k < NPORT; k++) begin : g_cnt
    assign frame_cnt[CW*k +: CW] = fcnt[k];
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt = '0;
  assign abort_cnt = '0;
`endif
  logic unused_ok;
  assign unused_ok = ^{in_c[10], cnt_clear, close_frame, close_drop, abort, jumbo_dw != 0};
endmodule

// File: tb/tb_emux_rxn.sv
// tb_emux_rxn: scoreboard bench for emux_rxn; two instances share the input bus to cover
// the reference port table and an overlapping-port table for priority.
module tb_emux_rxn;
  localparam logic [63:0] PA = {16'h0801, 16'h0800, 16'h0000, 16'h1F90};
  localparam logic [63:0] PB = {16'h0800, 16'h0801, 16'h0000, 16'h0800};
`ifdef EMUX_RXN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] in_c;
  logic cnt_clear;
  logic [11:0] out_c_a, out_c_b;
  logic [3:0] ready_a, ready_b, sel_a, sel_b;
  logic strobe_a, strobe_b, crc_a, crc_b, active_a, active_b;
  logic [7:0] data_a, data_b;
  logic [63:0] frame_a, frame_b;
  logic [15:0] drop_a, drop_b, abort_a, abort_b;
  int n_chk = 0, n_err = 0;
  int m_st[2], m_sel[2], m_drop[2], m_abort[2];
  int m_frame[2][4];
  logic [7:0] prev_d;
  logic [7:0] qs_a[$], qs_b[$];
  logic [8:0] qc_a[$], qc_b[$];

  always #5 clk = ~clk;

  emux_rxn #(.NPORT(4), .PORTS(PA), .CW(16), .jumbo_dw(14)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_c(in_c), .out_c(out_c_a), .ready(ready_a),
    .strobe(strobe_a), .crc(crc_a), .data(data_a), .sel_idx(sel_a), .active(active_a),
    .cnt_clear(cnt_clear), .frame_cnt(frame_a), .drop_cnt(drop_a), .abort_cnt(abort_a));

  emux_rxn #(.NPORT(4), .PORTS(PB), .CW(16), .jumbo_dw(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_c(in_c), .out_c(out_c_b), .ready(ready_b),
    .strobe(strobe_b), .crc(crc_b), .data(data_b), .sel_idx(sel_b), .active(active_b),
    .cnt_clear(cnt_clear), .frame_cnt(frame_b), .drop_cnt(drop_b), .abort_cnt(abort_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tbl(input int u, input int k);
    logic [63:0] p;
    p = u == 0 ? PA : PB;
    return p[16*k +: 16];
  endfunction

  function automatic logic [3:0] hits(input int u, input logic [15:0] port);
    logic [3:0] m = '0;
    for (int k = 0; k < 4; k++) m[k] = tbl(u, k) != 16'd0 && tbl(u, k) == port;
    return m;
  endfunction

  function automatic logic [63:0] fexp(input int u);
    logic [63:0] r = '0;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = STATS ? 16'(m_frame[u][k]) : 16'd0;
    return r;
  endfunction

  // Strobed bytes and CRC tokens are scoreboarded as the DUT emits them.
  always @(negedge clk) if (rst_n) begin
    if (strobe_a) begin
      if (qs_a.size() != 0) chk("data_a", data_a, qs_a.pop_front());
      else chk("strobe_a_extra", strobe_a, 1'b0);
    end
    if (strobe_b) begin
      if (qs_b.size() != 0) chk("data_b", data_b, qs_b.pop_front());
      else chk("strobe_b_extra", strobe_b, 1'b0);
    end
    if (crc_a) begin
      if (qc_a.size() != 0) chk("crc_a", {out_c_a[11], out_c_a[7:0]}, qc_a.pop_front());
      else chk("crc_a_extra", crc_a, 1'b0);
    end
    if (crc_b) begin
      if (qc_b.size() != 0) chk("crc_b", {out_c_b[11], out_c_b[7:0]}, qc_b.pop_front());
      else chk("crc_b_extra", crc_b, 1'b0);
    end
  end

  task automatic drv(input logic c, input logic s, input logic p, input logic [7:0] d, input logic clr = 1'b0);
    logic [3:0] m[2];
    @(posedge clk);
    #1;
    in_c = {c, 1'b0, s, p, d};
    cnt_clear = clr;
    for (int u = 0; u < 2; u++) begin
      m[u] = p ? hits(u, {prev_d, d}) : 4'b0;
      if (s && m_st[u] == 1) begin
        if (u == 0) qs_a.push_back(d);
        else qs_b.push_back(d);
      end
      if (c && m_st[u] == 1) begin
        if (u == 0) qc_a.push_back({1'b1, d});
        else qc_b.push_back({1'b1, d});
      end
    end
    @(negedge clk);
    chk("active_a", active_a, m_st[0] == 1);
    chk("active_b", active_b, m_st[1] == 1);
    if (m_st[0] == 1) chk("sel_a", sel_a, m_sel[0]);
    if (m_st[1] == 1) chk("sel_b", sel_b, m_sel[1]);
    chk("ready_a", ready_a, m[0]);
    chk("ready_b", ready_b, m[1]);
    for (int u = 0; u < 2; u++) begin
      if (c && m_st[u] == 1) m_frame[u][m_sel[u]]++;
      if (c && m_st[u] == 2) m_drop[u]++;
      if (p) begin
        if (!c && m_st[u] != 0) m_abort[u]++;
        m_st[u] = m[u] != 0 ? 1 : 2;
        for (int k = 3; k >= 0; k--) if (m[u][k]) m_sel[u] = k;
      end else if (c) m_st[u] = 0;
      if (clr) begin
        for (int k = 0; k < 4; k++) m_frame[u][k] = 0;
        m_drop[u] = 0;
        m_abort[u] = 0;
      end
    end
    prev_d = d;
  endtask

  task automatic chk_cnt();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    chk("frame_a", frame_a, fexp(0));
    chk("frame_b", frame_b, fexp(1));
    chk("drop_a", drop_a, STATS ? 16'(m_drop[0]) : 16'd0);
    chk("drop_b", drop_b, STATS ? 16'(m_drop[1]) : 16'd0);
    chk("abort_a", abort_a, STATS ? 16'(m_abort[0]) : 16'd0);
    chk("abort_b", abort_b, STATS ? 16'(m_abort[1]) : 16'd0);
  endtask

  task automatic hdr(input logic [15:0] port, input logic c);
    drv(1'b0, 1'b0, 1'b0, port[15:8]);
    drv(c, 1'b0, 1'b1, port[7:0]);
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      if (i == 2) drv(1'b0, 1'b0, 1'b0, 8'h55);
    end
  endtask

  task automatic frame(input logic [15:0] port, input int n);
    hdr(port, 1'b0);
    bytes(n);
    drv(1'b1, 1'b0, 1'b0, 8'hA5);
    chk_cnt();
  endtask

  task automatic reset_model();
    for (int u = 0; u < 2; u++) begin
      m_st[u] = 0;
      m_sel[u] = 0;
      m_drop[u] = 0;
      m_abort[u] = 0;
      for (int k = 0; k < 4; k++) m_frame[u][k] = 0;
    end
    prev_d = 8'h00;
  endtask

  task automatic check_reset();
    chk("rst_out_c_a", out_c_a, 12'h000);
    chk("rst_crc_a", crc_a, 1'b0);
    chk("rst_active_a", active_a, 1'b0);
    chk("rst_sel_a", sel_a, 4'd0);
    chk("rst_strobe_a", strobe_a, 1'b0);
    chk("rst_active_b", active_b, 1'b0);
    chk("rst_frame_a", frame_a, 64'd0);
    chk("rst_drop_a", drop_a, 16'd0);
    chk("rst_abort_a", abort_a, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_c = '0;
    cnt_clear = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(16'h0800, 6);
    frame(16'h1234, 4);
    frame(16'h0800, 3);
    hdr(16'h1F90, 1'b0);
    bytes(2);
    hdr(16'h0801, 1'b0);
    bytes(3);
    drv(1'b1, 1'b0, 1'b0, 8'h3C);
    chk_cnt();
    hdr(16'h1F90, 1'b0);
    bytes(2);
    hdr(16'h0800, 1'b1);
    bytes(2);
    drv(1'b1, 1'b0, 1'b0, 8'hC3);
    chk_cnt();
    frame(16'h0000, 2);
    hdr(16'h0801, 1'b0);
    bytes(1);
    drv(1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
    chk_cnt();
    frame(16'h1F90, 2);
    hdr(16'h0800, 1'b0);
    bytes(2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_c = '0;
    chk("rst_qs_a", qs_a.size(), 0);
    chk("rst_qc_a", qc_a.size(), 0);
    reset_model();
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bytes(3);
    drv(1'b1, 1'b0, 1'b0, 8'h77);
    chk_cnt();
    frame(16'h0801, 4);
    repeat (3) drv(1'b0, 1'b0, 1'b0, 8'h00);
    chk("left_qs_a", qs_a.size(), 0);
    chk("left_qs_b", qs_b.size(), 0);
    chk("left_qc_a", qc_a.size(), 0);
    chk("left_qc_b", qc_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
